// File: rtl/wide_add_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ripple_carry_adder, wide_add_seq
// Description : Multi-word adder that reuses a single W-bit ripple-carry
//               adder across WORDS words. It handles one word per clock,
//               starting with the least significant word.
// Revision    : 1.0 - initial release
// ============================================================================

// N-bit ripple-carry adder. The carry passes bit by bit from LSB to MSB.
module ripple_carry_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    // Compute each full-adder stage in bit order and pass the carry upward.
    always_comb begin : p_ripple
        logic carry;
        carry = ci;
        s     = '0;
        for (int i = 0; i < N; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

module wide_add_seq #(
    parameter int W     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W*WORDS-1:0] a,
    input  logic [W*WORDS-1:0] b,
    input  logic               carry_in,
    output logic               busy,
    output logic               done,
    output logic [W*WORDS-1:0] sum,
    output logic               carry_out
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TW   = W * WORDS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [TW-1:0]   a_q, a_d;
    logic [TW-1:0]   b_q, b_d;
    logic            c_q, c_d;
    logic [TW-1:0]   sum_q, sum_d;
    logic            carry_out_q, carry_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [31:0]     w_base;
    logic [W-1:0]    w_add_a;
    logic [W-1:0]    w_add_b;
    logic [W-1:0]    w_add_sum;
    logic            w_add_co;

    // Select the current word of each captured operand. Its bit offset follows the word index.
    always_comb begin
        w_base  = 32'(idx_q) * 32'(W);
        w_add_a = a_q[w_base +: W];
        w_add_b = b_q[w_base +: W];
    end

    // The single shared word adder. Every RUN cycle uses it.
    ripple_carry_adder #(
        .N (W)
    ) u_adder (
        .a  (w_add_a),
        .b  (w_add_b),
        .ci (c_q),
        .s  (w_add_sum),
        .co (w_add_co)
    );

    // Next-state logic. busy and done are derived from the next state, so the outputs are registered.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = carry_in;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[w_base +: W] = w_add_sum;
                c_d                = w_add_co;
                if (idx_q == IDXW'(WORDS - 1)) begin
                    // On the last word, the index returns to 0 so it stays within range.
                    carry_out_d = w_add_co;
                    idx_d       = '0;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State registers. Reset overrides any start request or pending transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wide_add_seq
// Description : Directed-vector and sequence bench for wide_add_seq
//               with W=8 and WORDS=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_seq;

    localparam int W     = 8;
    localparam int WORDS = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        carry_out;

    int n_checks;
    int n_fail;
    int n_done_mon;
    int n_done_exp;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        co;
    } vec_t;

    vec_t vecs[8];

    wide_add_seq #(
        .W     (W),
        .WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse. The total is compared with the number of accepted operations.
    always @(negedge clk) begin
        if (done === 1'b1) n_done_mon++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pulse start with the given operands and scramble the inputs while the operation runs.
    // Then wait, with a time limit, for done. lat counts edges after the start-sampling edge.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                          output logic [31:0] s, output logic co, output logic bsy,
                          output int lat);
        @(negedge clk);
        a = ta; b = tb; carry_in = tc; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        bsy      = busy;
        a        = $urandom;
        b        = $urandom;
        carry_in = 1'($urandom_range(0, 1));
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        s  = sum;
        co = carry_out;
    endtask

    initial begin
        logic [31:0] s;
        logic        co;
        logic        bsy;
        logic [32:0] ref_full;
        logic [31:0] ra, rb;
        logic        rc;
        int          lat;
        int          cnt;
        int          last;

        n_checks = 0; n_fail = 0; n_done_mon = 0; n_done_exp = 0;

        vecs[0] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[5] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[6] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
        vecs[7] = '{32'h00FF00FF, 32'hFF00FF00, 1'b1, 32'h00000000, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(carry_out), 64'd0);

        // Directed vectors from the table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, bsy, lat);
            n_done_exp++;
            chk($sformatf("vec%0d_busy", i), 64'(bsy), 64'd1);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(WORDS));
            chk($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].co));
            @(negedge clk);
            chk($sformatf("vec%0d_done_width", i), 64'(done), 64'd0);
            chk($sformatf("vec%0d_idle_busy", i), 64'(busy), 64'd0);
            chk($sformatf("vec%0d_sum_hold", i), 64'(sum), 64'(vecs[i].sum));
        end

        // A start pulse during RUN must be ignored
        @(negedge clk);
        a = 32'h01020304; b = 32'h10203040; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; carry_in = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", 64'(busy), 64'd1);
        lat = 2;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        n_done_exp++;
        chk("ign_latency", 64'(lat), 64'(WORDS));
        chk("ign_sum", 64'(sum), 64'h11223344);
        chk("ign_cout", 64'(carry_out), 64'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        chk("ign_extra_done", 64'(cnt), 64'd0);

        // Reset asserted in the middle of an operation
        @(negedge clk);
        a = 32'h01020304; b = 32'h10203040; carry_in = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cout", 64'(carry_out), 64'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        chk("abort_no_done", 64'(cnt), 64'd0);

        // start held high for 20 edges: one operation every WORDS+2 cycles
        @(negedge clk);
        a = 32'h80000000; b = 32'h80000000; carry_in = 1'b0; start = 1'b1;
        cnt = 0; last = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 19) start = 1'b0;
            if (done === 1'b1) begin
                cnt++;
                chk("held_sum", 64'(sum), 64'd0);
                chk("held_cout", 64'(carry_out), 64'd1);
                if (last >= 0) chk("held_period", 64'(i - last), 64'(WORDS + 2));
                last = i;
            end
        end
        n_done_exp += 4;
        chk("held_done_count", 64'(cnt), 64'd4);

        // Random operands with random gaps, compared against a 33-bit reference sum
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            ref_full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            run_op(ra, rb, rc, s, co, bsy, lat);
            n_done_exp++;
            chk("rand_latency", 64'(lat), 64'(WORDS));
            chk("rand_sum", 64'(s), 64'(ref_full[31:0]));
            chk("rand_cout", 64'(co), 64'(ref_full[32]));
        end

        @(negedge clk);
        @(negedge clk);
        chk("done_count", 64'(n_done_mon), 64'(n_done_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter W, default 8, giving the word width of the shared adder.
REQ-002 SHALL have parameter WORDS, default 4, giving the operand length in words (WORDS >= 2).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request to begin an addition; honoured only in IDLE.
REQ-007 a  input  W*WORDS  operand A, word k = a[k*W +: W].
REQ-008 b  input  W*WORDS  operand B, same word layout.
REQ-009 carry_in  input  1  carry into word 0.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse: result valid.
REQ-012 sum  output  W*WORDS  registered result.
REQ-013 carry_out  output  1  registered carry out of word WORDS-1.

Function
REQ-014 SHALL use exactly one W-bit ripple-carry adder instance (team adder, N=W), time-shared across words; no second adder.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE: on an edge with start=1, SHALL capture a, b, carry_in into internal registers, clear word index to 0, and go to RUN; start=0 stays IDLE.
REQ-017 RUN: each edge SHALL write sum word[idx] <= A[idx]+B[idx]+c (low W bits), c <= adder carry, idx <= idx+1.
REQ-018 RUN: on the edge processing idx=WORDS-1, SHALL load carry_out with the adder carry and go to DONE.
REQ-019 DONE: done SHALL be 1 for exactly this one cycle; next edge SHALL go to IDLE.
REQ-020 Latency: start sampled at edge E0; done high in the cycle after edge E0+WORDS (WORDS+1 edges start-to-done).
REQ-021 start in RUN or DONE SHALL be ignored (no capture, no restart, no queueing).
REQ-022 Changes on a, b, carry_in after capture SHALL NOT affect the operation in progress.
REQ-023 sum words not yet written in RUN SHALL hold prior values; sum and carry_out SHALL be valid only while done=1, then hold until overwritten by the next operation.
REQ-024 start held continuously high SHALL give one operation per WORDS+2 cycles (re-accept in first IDLE cycle after DONE).
REQ-025 Result SHALL equal (A + B + carry_in) mod 2^(W*WORDS), with carry_out = bit W*WORDS of the full sum.
REQ-026 Word index SHALL be ceil(log2(WORDS)) bits wide and never exceed WORDS-1.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, idx=0, internal carry=0, sum=0, carry_out=0; busy=0, done=0 in the following cycle.
REQ-028 rst SHALL take priority over start and over any RUN/DONE transition, including mid-operation; the aborted operation SHALL produce no done pulse.

Verification (W=8, WORDS=4)
REQ-029 a=0x12345678, b=0x11111111, carry_in=1, start pulse -> done at start+5 edges, sum=0x2345678A, carry_out=0.
REQ-030 a=0xFFFFFFFF, b=0x00000001, carry_in=0 -> sum=0x00000000, carry_out=1 (carry ripples through all four words).
REQ-031 Start op (a=0x01020304, b=0x10203040), at the second RUN edge drive a=b=0xFFFFFFFF and pulse start -> ignored; sum=0x11223344, carry_out=0, single done pulse.
REQ-032 rst asserted at the second RUN edge -> next cycle busy=0, done=0, sum=0, carry_out=0; no done pulse until a new start.
REQ-033 start held high 20 cycles, a=b=0x80000000 -> done pulses every 6 cycles, each sum=0x00000000, carry_out=1.
REQ-034 Random a, b, carry_in, 1000 ops, random start gaps -> every done matches the 33-bit reference sum; done count equals accepted-start count.
